// File: rtl/input_handshake_pkg.sv
// Shared types and constants for the switch/button input conditioner.
// The state encoding is shared so that other blocks can decode the FSM state.
package input_handshake_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DB,
      ARM,
      HELD,
      REL_DB
   } hs_state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for asynchronous levels entering the clk domain.
// All flops are cleared by the synchronous reset.
module bit_synchronizer
   import input_handshake_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

   // NOTE: sequential state is written with non-blocking assignments only, so every
   // flop samples the pre-edge value of its neighbour and the chain shifts by one stage per clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage <= '0;
      end else begin
         stage <= {stage[SYNC_STAGES-2:0], d};
      end
   end

   assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/input_handshake.sv
// Conditions the raw switch bank and push-button into the sw / ready_in pair
// for the CPU. sw is presented one cycle (ARM) before ready_in rises.
module input_handshake
   import input_handshake_pkg::*;
#(
   parameter int BUS_WIDTH       = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BUS_WIDTH-1:0] sw_raw,
   input  logic                 btn_raw,
   output logic [BUS_WIDTH-1:0] sw,
   output logic                 ready_in,
   output logic [7:0]           press_count
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic                 btn_s;
   logic [BUS_WIDTH-1:0] sw_s;

   hs_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 load_sw;
   logic                 ready_d;

   bit_synchronizer #(.WIDTH(1)) u_btn_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_raw),
      .q     (btn_s)
   );

   bit_synchronizer #(.WIDTH(BUS_WIDTH)) u_sw_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw_raw),
      .q     (sw_s)
   );

   // NOTE: every signal written here gets a default first, so no path can leave one
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      load_sw = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (btn_s) state_d = PRESS_DB;
         end
         PRESS_DB: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ARM;
               cnt_d   = '0;
               load_sw = 1'b1;
            end
         end
         ARM: begin
            state_d = HELD;
            cnt_d   = '0;
         end
         HELD: begin
            cnt_d = '0;
            if (!btn_s) state_d = REL_DB;
         end
         REL_DB: begin
            // A bounce back high restarts the release qualification from HELD.
            if (btn_s) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // ready_in is registered from the next state so it is glitch-free flop output.
      ready_d = (state_d == HELD) || (state_d == REL_DB);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sw          <= '0;
         ready_in    <= 1'b0;
         press_count <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_in <= ready_d;
         if (load_sw) begin
            sw          <= sw_s;
            press_count <= press_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_input_handshake.sv
// Scenario bench for input_handshake with DEBOUNCE_CYCLES=4: expected sw/press_count
// pairs are queued at press start and matched on each ready_in rising edge.
module tb_input_handshake;

   localparam int BW = 8;
   localparam int D  = 4;

   typedef struct {
      logic [BW-1:0] sw;
      logic [7:0]    cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [BW-1:0] sw_raw;
   logic          btn_raw;
   logic [BW-1:0] sw;
   logic          ready_in;
   logic [7:0]    press_count;

   int            total = 0;
   int            bad   = 0;
   logic [7:0]    exp_count = 8'd0;
   logic [BW-1:0] exp_sw    = '0;
   exp_t          sb[$];
   exp_t          e;
   logic          ready_prev = 1'b0;

   always #5 clk = ~clk;

   input_handshake #(
      .BUS_WIDTH       (BW),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sw_raw      (sw_raw),
      .btn_raw     (btn_raw),
      .sw          (sw),
      .ready_in    (ready_in),
      .press_count (press_count)
   );

   // Scoreboard: every ready_in rising edge must match the oldest pending press.
   always @(negedge clk) begin
      if (ready_in === 1'b1 && ready_prev !== 1'b1) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_unexpected_rise: ready_in rose with no press pending (sw=%h count=%0d)", sw, press_count);
         end else begin
            e = sb.pop_front();
            total++;
            if (sw !== e.sw) begin
               bad++;
               $display("FAIL sb_sw: got %h expected %h", sw, e.sw);
            end
            total++;
            if (press_count !== e.cnt) begin
               bad++;
               $display("FAIL sb_count: got %0d expected %0d", press_count, e.cnt);
            end
         end
      end
      ready_prev = ready_in;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just after an edge, so the following edge is E0 of the press.
   task automatic press_start(input logic [BW-1:0] v);
      sw_raw  = v;
      btn_raw = 1'b1;
      exp_count = exp_count + 8'd1;
      exp_sw    = v;
      sb.push_back('{sw: v, cnt: exp_count});
   endtask

   task automatic test_reset;
      reset = 1'b1; btn_raw = 1'b1; sw_raw = 8'hFF;
      tick(2);
      total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b expected 0", ready_in); end
      total++; if (sw !== 8'h00) begin bad++; $display("FAIL reset_sw: got %h expected 00", sw); end
      total++; if (press_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", press_count); end
      // Button still held at deassertion is a new press.
      reset = 1'b0;
      exp_count = 8'd1; exp_sw = 8'hFF;
      sb.push_back('{sw: 8'hFF, cnt: 8'd1});
      tick(7); // through E6
      total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL reset_press_early: ready_in got %b expected 0 after E6", ready_in); end
      total++; if (sw !== 8'hFF) begin bad++; $display("FAIL reset_press_sw: got %h expected FF", sw); end
      total++; if (press_count !== 8'd1) begin bad++; $display("FAIL reset_press_count: got %0d expected 1", press_count); end
      tick(1); // E7
      total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL reset_press_ready: got %b expected 1 after E7", ready_in); end
      btn_raw = 1'b0;
      tick(7);
      total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL reset_release: got %b expected 0", ready_in); end
   endtask

   task automatic test_clean_press;
      reset = 1'b1; btn_raw = 1'b0; sw_raw = 8'hA5;
      tick(2);
      reset = 1'b0;
      exp_count = 8'd0; exp_sw = '0;
      press_start(8'hA5);
      tick(6); // through E5
      total++; if (sw !== 8'h00) begin bad++; $display("FAIL clean_sw_early: got %h expected 00 after E5", sw); end
      tick(1); // E6
      total++; if (sw !== 8'hA5) begin bad++; $display("FAIL clean_sw: got %h expected A5 after E6", sw); end
      total++; if (press_count !== 8'd1) begin bad++; $display("FAIL clean_count: got %0d expected 1", press_count); end
      total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL clean_arm: ready_in got %b expected 0 after E6", ready_in); end
      tick(1); // E7
      total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL clean_ready: got %b expected 1 after E7", ready_in); end
      tick(12); // button held 20 cycles in total
      total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL clean_hold: got %b expected 1", ready_in); end
      btn_raw = 1'b0;
      tick(6);
      total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL clean_release_early: got %b expected 1 after F5", ready_in); end
      tick(1);
      total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL clean_release: got %b expected 0 after F6", ready_in); end
      total++; if (press_count !== 8'd1) begin bad++; $display("FAIL clean_count_end: got %0d expected 1", press_count); end
   endtask

   task automatic test_glitch;
      int lens[2] = '{3, D};
      foreach (lens[k]) begin
         sw_raw = 8'h11; btn_raw = 1'b1;
         tick(lens[k]);
         btn_raw = 1'b0;
         tick(12);
         total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL glitch_ready len=%0d: got %b expected 0", lens[k], ready_in); end
         total++; if (sw !== exp_sw) begin bad++; $display("FAIL glitch_sw len=%0d: got %h expected %h", lens[k], sw, exp_sw); end
         total++; if (press_count !== exp_count) begin bad++; $display("FAIL glitch_count len=%0d: got %0d expected %0d", lens[k], press_count, exp_count); end
      end
   endtask

   task automatic test_release_bounce;
      int dips[2] = '{2, D};
      press_start(8'hA5);
      tick(12);
      total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL bounce_held: got %b expected 1", ready_in); end
      foreach (dips[k]) begin
         btn_raw = 1'b0;
         for (int t = 0; t < dips[k] + 10; t++) begin
            if (t == dips[k]) btn_raw = 1'b1;
            tick(1);
            total++;
            if (ready_in !== 1'b1) begin
               bad++;
               $display("FAIL bounce_gap dip=%0d t=%0d: got %b expected 1", dips[k], t, ready_in);
            end
         end
      end
      total++; if (press_count !== exp_count) begin bad++; $display("FAIL bounce_count: got %0d expected %0d", press_count, exp_count); end
   endtask

   task automatic test_switch_change;
      sw_raw = 8'h3C;
      tick(10);
      total++; if (sw !== 8'hA5) begin bad++; $display("FAIL swchg_held: got %h expected A5", sw); end
      btn_raw = 1'b0;
      tick(7);
      total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL swchg_release: got %b expected 0", ready_in); end
      total++; if (sw !== 8'hA5) begin bad++; $display("FAIL swchg_idle_sw: got %h expected A5", sw); end
      press_start(8'h3C);
      tick(7);
      total++; if (sw !== 8'h3C) begin bad++; $display("FAIL swchg_next_sw: got %h expected 3C", sw); end
      tick(1);
      total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL swchg_next_ready: got %b expected 1", ready_in); end
      btn_raw = 1'b0;
      tick(7);
   endtask

   task automatic test_reset_held_wrap;
      press_start(8'h5A);
      tick(10);
      total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL rsthold_held: got %b expected 1", ready_in); end
      reset = 1'b1; btn_raw = 1'b0;
      tick(1);
      total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL rsthold_ready: got %b expected 0", ready_in); end
      total++; if (press_count !== 8'd0) begin bad++; $display("FAIL rsthold_count: got %0d expected 0", press_count); end
      total++; if (sw !== 8'h00) begin bad++; $display("FAIL rsthold_sw: got %h expected 00", sw); end
      exp_count = 8'd0; exp_sw = '0;
      tick(1);
      reset = 1'b0;
      for (int i = 0; i < 256; i++) begin
         press_start(8'(i) ^ 8'h5A);
         tick(9);
         btn_raw = 1'b0;
         tick(7);
      end
      total++; if (press_count !== 8'd0) begin bad++; $display("FAIL wrap_count: got %0d expected 0", press_count); end
      total++; if (sw !== exp_sw) begin bad++; $display("FAIL wrap_sw: got %h expected %h", sw, exp_sw); end
      total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL wrap_ready: got %b expected 0", ready_in); end
   endtask

   initial begin
      reset = 1'b1; btn_raw = 1'b0; sw_raw = '0;
      test_reset();
      test_clean_press();
      test_glitch();
      test_release_bounce();
      test_switch_change();
      test_reset_held_wrap();
      tick(2);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_pending: %0d presses never raised ready_in, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/input_handshake.md
# input_handshake

Conditions the board's raw switch bank and push-button into the clean `sw` / `ready_in` pair that the CPU consumes. It sits directly upstream of the CPU's input port. It synchronises both inputs, debounces the button with a press/release state machine, and snapshots the switches once per accepted press. It sequences the outputs so that `sw` is stable at least one cycle before `ready_in` rises, because the CPU registers `sw` one cycle late and acts on the `ready_in` rising edge.

## Interface
- `BUS_WIDTH`, 8, width of switch bus and `sw` output
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required to accept a press or release; legal range ≥ 2
- `clk`  in  1  single system clock
- `reset`  in  1  reset; one clock; reset is synchronous and active-high
- `sw_raw`  in  BUS_WIDTH  asynchronous switch levels
- `btn_raw`  in  1  asynchronous push-button level, 1 = pressed
- `sw`  out  BUS_WIDTH  switch snapshot for the current press; reset 0
- `ready_in`  out  1  debounced press level, flop-driven; reset 0
- `press_count`  out  8  count of accepted presses, wraps 255→0; reset 0

## Operation
- **Synchronisers.** `btn_raw` and `sw_raw` each pass through a 2-flop synchroniser, producing `btn_s` and `sw_s`. Multi-bit skew on `sw_s` is harmless because it is sampled only after debounce.
- **Counter.** Width is clog2(DEBOUNCE_CYCLES). It is cleared on every state entry.
- **IDLE.** `ready_in`=0. Go to PRESS_DB when `btn_s`=1.
- **PRESS_DB.**
  - If `btn_s`=0, return to IDLE. This is a glitch: no outputs change.
  - Otherwise increment the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 with `btn_s`=1: load `sw` ← `sw_s`, increment `press_count`, and go to ARM.
- **ARM.** One cycle. `ready_in` stays 0 while the new `sw` is presented. Go to HELD unconditionally.
- **HELD.** `ready_in`=1. Go to REL_DB when `btn_s`=0.
- **REL_DB.**
  - `ready_in` stays 1.
  - If `btn_s`=1, return to HELD. This is release bounce.
  - Otherwise count. When the counter reaches DEBOUNCE_CYCLES-1 with `btn_s`=0, go to IDLE.
- **`sw` register.** Written only on the PRESS_DB→ARM transition. It holds through HELD, REL_DB, IDLE and any rejected glitches.
- **Reset.**
  - Reset at any time, including mid-press, forces the outputs and state to their reset values: IDLE, counter 0, synchroniser flops 0, all outputs 0.
  - A button still held at reset deassertion is treated as a new press.
- **No duplicate presses.** A continuous hold produces exactly one press.

## Timing
- Edge E0 is the first edge that samples `btn_raw`=1, held steady. The sequence is:
  - `btn_s`=1 after E1.
  - State is PRESS_DB after E2.
  - `sw` and `press_count` update after edge E(2+D).
  - `ready_in`=1 after E(3+D).
  - Total press latency is D+3 cycles.
- Release: `ready_in`=0 after E(2+D) counted from the first edge sampling `btn_raw`=0, with the button held steady low.
- `sw` is stable ≥1 cycle before the `ready_in` rising edge. It stays stable for the whole `ready_in` high period and until the next accepted press.
- Minimum `ready_in` high time is D+1 cycles. Minimum low time between presses is D+2 cycles.
- Rejection thresholds:
  - A press pulse shorter than D+1 cycles at `btn_s` never raises `ready_in`.
  - A release dip shorter than D+1 cycles never lowers it.

## Structure
- Shared package `input_handshake_pkg`:
  - `hs_state_t` enum: IDLE, PRESS_DB, ARM, HELD, REL_DB.
  - `SYNC_STAGES` = 2.
- Sub-module `bit_synchronizer`:
  - Parameter WIDTH; SYNC_STAGES flops; synchronous active-high reset.
  - Instantiated once for `btn_raw` (WIDTH 1) and once for `sw_raw` (WIDTH BUS_WIDTH).
- The FSM, counter, `sw` register and `press_count` live in the top module.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.

1. **Reset values.** Assert `reset` for 2 cycles with `btn_raw`=1 and `sw_raw`=0xFF → during reset `ready_in`=0, `sw`=0x00, `press_count`=0. After deassert, `ready_in` rises 7 edges later with `sw`=0xFF and `press_count`=1.
2. **Clean press.** `sw_raw`=0xA5, `btn_raw` high for 20 cycles from E0 → `sw`=0xA5 after E6, `ready_in`=1 after E7. Release → `ready_in`=0 6 edges later. `press_count`=1.
3. **Glitch rejection.** `btn_raw` high for 3 cycles → `ready_in` stays 0, `sw` unchanged, `press_count` unchanged.
4. **Release bounce.** In HELD, drop `btn_raw` for 2 cycles then raise it again → `ready_in` stays 1 with no gap, and `press_count` does not change.
5. **Switch change while held.** `sw_raw` changes to 0x3C during HELD → `sw` remains 0xA5. The next press yields `sw`=0x3C.
6. **Reset in HELD and counter wrap.**
   - Assert `reset` during HELD → `ready_in`=0 after that edge.
   - Perform 256 clean presses → `press_count` returns to 0.
